// File: rtl/boot_rom_loader.sv
// Copies a checksummed boot image from ROM into RAM after a start pulse.
// Latency: header at edge 1, payload word i written after edge i+2, result after edge len+2.
// No backpressure: one RAM write per cycle, start is ignored while busy.
module boot_rom_loader #(
    parameter logic [15:0] ROM_BASE  = 16'h0000,
    parameter logic [15:0] RAM_BASE  = 16'h0000,
    parameter logic [15:0] MAGIC     = 16'h82BF,
    parameter logic [15:0] MAX_WORDS = 16'h8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [15:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [15:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_write,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] loaded_words
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HEADER = 3'd1;
    localparam logic [2:0] COPY   = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERROR  = 3'd5;

    logic [2:0]  state;
    logic [15:0] len;
    logic [31:0] sum;

    // Status flags are pure decodes of the state so they follow reset instantly.
    always_comb begin
        busy  = (state == HEADER) || (state == COPY) || (state == CHECK);
        done  = (state == DONE) || (state == ERROR);
        error = (state == ERROR);
    end

    // Load sequencer: header decode, payload streaming, checksum compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rom_address  <= ROM_BASE;
            ram_address  <= 16'h0000;
            ram_data     <= 32'h0000_0000;
            ram_write    <= 1'b0;
            loaded_words <= 16'h0000;
            len          <= 16'h0000;
            sum          <= 32'h0000_0000;
        end else begin
            // The write strobe is a single-cycle pulse per COPY sample.
            ram_write <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state        <= HEADER;
                        rom_address  <= ROM_BASE;
                        loaded_words <= 16'h0000;
                    end
                end
                HEADER: begin
                    len          <= rom_data[15:0];
                    sum          <= 32'h0000_0000;
                    loaded_words <= 16'h0000;
                    if ((rom_data[31:16] != MAGIC) || (rom_data[15:0] > MAX_WORDS)) begin
                        state <= ERROR;
                    end else begin
                        rom_address <= ROM_BASE + 16'd1;
                        // An empty image goes straight to the checksum word.
                        state       <= (rom_data[15:0] == 16'h0000) ? CHECK : COPY;
                    end
                end
                COPY: begin
                    sum          <= sum + rom_data;
                    ram_data     <= rom_data;
                    ram_address  <= RAM_BASE + loaded_words;
                    ram_write    <= 1'b1;
                    loaded_words <= loaded_words + 16'd1;
                    rom_address  <= rom_address + 16'd1;
                    // After the last payload word rom_address lands on the checksum.
                    if ((loaded_words + 16'd1) == len) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    state <= (rom_data == sum) ? DONE : ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_rom_loader.sv
// Bench for boot_rom_loader: two instances (default MAX_WORDS and MAX_WORDS=4) share one ROM.
// Latency: outputs compared every negedge against an image-level model.
// No backpressure on the DUT; the bench only times start pulses and resets.
module tb_boot_rom_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] rom_address  [2];
    logic [31:0] rom_data     [2];
    logic [15:0] ram_address  [2];
    logic [31:0] ram_data     [2];
    logic        ram_write    [2];
    logic        busy         [2];
    logic        done         [2];
    logic        error        [2];
    logic [15:0] loaded_words [2];

    logic [31:0] rom [0:255];

    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;

    boot_rom_loader u0 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rom_address(rom_address[0]), .rom_data(rom_data[0]),
        .ram_address(ram_address[0]), .ram_data(ram_data[0]), .ram_write(ram_write[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .loaded_words(loaded_words[0])
    );

    boot_rom_loader #(.MAX_WORDS(16'd4)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rom_address(rom_address[1]), .rom_data(rom_data[1]),
        .ram_address(ram_address[1]), .ram_data(ram_data[1]), .ram_write(ram_write[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .loaded_words(loaded_words[1])
    );

    assign rom_data[0] = rom[rom_address[0][7:0]];
    assign rom_data[1] = rom[rom_address[1][7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- image-level model ----------------
    // m_k = number of edges since the edge that accepted start.
    bit          m_run [2];
    int          m_k   [2];
    bit          m_ok  [2];
    int          m_len [2];
    bit          m_err [2];

    function automatic int max_words(input int i);
        return (i == 0) ? 32'h8000 : 4;
    endfunction

    function automatic bit m_busy(input int i);
        if (!m_run[i]) return 1'b0;
        if (!m_ok[i]) return (m_k[i] == 0);
        return (m_k[i] <= m_len[i] + 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] <= 1'b0;
                m_k[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start && !m_busy(i)) begin
                    logic [31:0] hdr;
                    logic [31:0] s;
                    int          n;
                    hdr = rom[0];
                    n   = int'(hdr[15:0]);
                    s   = 32'h0;
                    for (int j = 1; j <= n && j < 255; j++) s = s + rom[j];
                    m_run[i] <= 1'b1;
                    m_k[i]   <= 0;
                    m_len[i] <= n;
                    m_ok[i]  <= (hdr[31:16] == 16'h82BF) && (n <= max_words(i));
                    m_err[i] <= (n < 255) ? (s != rom[n + 1]) : 1'b1;
                end else if (m_run[i] && m_k[i] < 100000) begin
                    m_k[i] <= m_k[i] + 1;
                end
            end
        end
    end

    task automatic compare_one(input int i);
        int k;
        k = m_k[i];
        if (!m_run[i]) begin
            check($sformatf("u%0d idle busy", i), 32'(busy[i]), 0);
            check($sformatf("u%0d idle done", i), 32'(done[i]), 0);
            check($sformatf("u%0d idle error", i), 32'(error[i]), 0);
            check($sformatf("u%0d idle ram_write", i), 32'(ram_write[i]), 0);
            check($sformatf("u%0d idle loaded", i), 32'(loaded_words[i]), 0);
            check($sformatf("u%0d idle rom_address", i), 32'(rom_address[i]), 0);
            check($sformatf("u%0d idle ram_address", i), 32'(ram_address[i]), 0);
            check($sformatf("u%0d idle ram_data", i), ram_data[i], 0);
        end else if (!m_ok[i]) begin
            check($sformatf("u%0d hdrfail busy", i), 32'(busy[i]), 32'(k == 0));
            check($sformatf("u%0d hdrfail done", i), 32'(done[i]), 32'(k >= 1));
            check($sformatf("u%0d hdrfail error", i), 32'(error[i]), 32'(k >= 1));
            check($sformatf("u%0d hdrfail ram_write", i), 32'(ram_write[i]), 0);
            check($sformatf("u%0d hdrfail loaded", i), 32'(loaded_words[i]), 0);
        end else if (k <= m_len[i] + 1) begin
            bit wr;
            wr = (k >= 2);
            check($sformatf("u%0d run busy k=%0d", i, k), 32'(busy[i]), 1);
            check($sformatf("u%0d run done k=%0d", i, k), 32'(done[i]), 0);
            check($sformatf("u%0d run error k=%0d", i, k), 32'(error[i]), 0);
            check($sformatf("u%0d run ram_write k=%0d", i, k), 32'(ram_write[i]), 32'(wr));
            check($sformatf("u%0d run loaded k=%0d", i, k), 32'(loaded_words[i]), wr ? 32'(k - 1) : 0);
            check($sformatf("u%0d run rom_address k=%0d", i, k), 32'(rom_address[i]), 32'(k));
            if (wr) begin
                check($sformatf("u%0d ram_address k=%0d", i, k), 32'(ram_address[i]), 32'(k - 2));
                check($sformatf("u%0d ram_data k=%0d", i, k), ram_data[i], rom[k - 1]);
            end
        end else begin
            check($sformatf("u%0d end busy", i), 32'(busy[i]), 0);
            check($sformatf("u%0d end done", i), 32'(done[i]), 1);
            check($sformatf("u%0d end error", i), 32'(error[i]), 32'(m_err[i]));
            check($sformatf("u%0d end ram_write", i), 32'(ram_write[i]), 0);
            check($sformatf("u%0d end loaded", i), 32'(loaded_words[i]), 32'(m_len[i]));
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            compare_one(0);
            compare_one(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [31:0] img[$]);
        for (int i = 0; i < img.size(); i++) rom[i] = img[i];
    endtask

    // Returns at the negedge just after edge 0.
    task automatic go();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(done[0] && done[1]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(done[0] && done[1])) begin
            tests++;
            fails++;
            $display("FAIL wait_done timeout: done=%b%b after %0d cycles", done[0], done[1], n);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        #1;
        check("reset rom_address", 32'(rom_address[0]), 0);
        check("reset busy", 32'(busy[0]), 0);
        check("reset done", 32'(done[0]), 0);
        check("reset ram_write", 32'(ram_write[0]), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Nominal image, with a start pulse while busy.
        load('{32'h82BF0003, 32'd1, 32'd2, 32'd3, 32'd6});
        go();
        repeat (2) @(negedge clk);
        check("nom edge2 ram_write", 32'(ram_write[0]), 1);
        check("nom edge2 ram_address", 32'(ram_address[0]), 0);
        check("nom edge2 ram_data", ram_data[0], 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nom edge3 ram_data", ram_data[0], 2);
        check("nom edge3 ram_address", 32'(ram_address[0]), 1);
        @(negedge clk);
        check("nom edge4 ram_data", ram_data[0], 3);
        @(negedge clk);
        check("nom edge5 done", 32'(done[0]), 1);
        check("nom edge5 error", 32'(error[0]), 0);
        check("nom edge5 loaded", 32'(loaded_words[0]), 3);
        check("nom edge5 ram_write", 32'(ram_write[0]), 0);
        wait_done(20);

        // Bad magic.
        load('{32'h12340003, 32'd1, 32'd2, 32'd3, 32'd6});
        go();
        @(negedge clk);
        check("magic edge1 done", 32'(done[0]), 1);
        check("magic edge1 error", 32'(error[0]), 1);
        check("magic edge1 loaded", 32'(loaded_words[0]), 0);
        wait_done(20);

        // Bad checksum.
        load('{32'h82BF0002, 32'd5, 32'd9, 32'd15});
        go();
        repeat (3) @(negedge clk);
        check("cks edge3 error", 32'(error[0]), 0);
        @(negedge clk);
        check("cks edge4 error", 32'(error[0]), 1);
        check("cks edge4 loaded", 32'(loaded_words[0]), 2);
        wait_done(20);

        // Length above MAX_WORDS=4 on u1; u0 accepts the same image.
        load('{32'h82BF0005, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd15});
        go();
        @(negedge clk);
        check("len u1 edge1 error", 32'(error[1]), 1);
        check("len u0 edge1 busy", 32'(busy[0]), 1);
        wait_done(30);
        check("len u0 loaded", 32'(loaded_words[0]), 5);
        check("len u0 error", 32'(error[0]), 0);

        // Empty image.
        load('{32'h82BF0000, 32'd0});
        go();
        @(negedge clk);
        check("empty edge1 busy", 32'(busy[0]), 1);
        @(negedge clk);
        check("empty edge2 done", 32'(done[0]), 1);
        check("empty edge2 error", 32'(error[0]), 0);
        wait_done(20);

        // Reset after the second write of the nominal image, then reload.
        load('{32'h82BF0003, 32'd1, 32'd2, 32'd3, 32'd6});
        go();
        repeat (3) @(negedge clk);
        check("rst pre ram_data", ram_data[0], 2);
        #2 reset_n = 1'b0;
        #1;
        check("rst ram_write", 32'(ram_write[0]), 0);
        check("rst busy", 32'(busy[0]), 0);
        check("rst loaded", 32'(loaded_words[0]), 0);
        check("rst rom_address", 32'(rom_address[0]), 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post-rst no write", 32'(ram_write[0]), 0);
        go();
        wait_done(20);
        check("reload done", 32'(done[0]), 1);
        check("reload error", 32'(error[0]), 0);
        check("reload loaded", 32'(loaded_words[0]), 3);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
